// File: rtl/counter_multi.sv
// counter_multi: bank of CHANNELS up/down counters with clamped load, MAX_VAL wrap and registered tc pulse.
// Define COUNTER_MULTI_CASCADE_EN to chain channel i to the wrap of channel i-1 (multi-digit counter).
module counter_multi #(
  parameter int          WIDTH    = 4,
  parameter int          CHANNELS = 2,
  parameter int unsigned MAX_VAL  = 2**WIDTH-1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       up,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       tc
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  logic [CHANNELS-1:0]       en_eff, wrap;
  logic [CHANNELS*WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0]          qi, lv;
`ifdef COUNTER_MULTI_CASCADE_EN
  logic                      carry;
`endif
  always_comb begin
    en_eff = en;
    wrap   = '0;
    q_nxt  = q;
    qi     = '0;
    lv     = '0;
`ifdef COUNTER_MULTI_CASCADE_EN
    carry  = 1'b1;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      qi = q[i*WIDTH +: WIDTH];
      lv = load_val[i*WIDTH +: WIDTH];
`ifdef COUNTER_MULTI_CASCADE_EN
      en_eff[i] = en[i] & carry;
`endif
      wrap[i] = en_eff[i] & ~clr & ~load[i] & (up[i] ? qi == MAXV : qi == '0);
`ifdef COUNTER_MULTI_CASCADE_EN
      carry = wrap[i];
`endif
      q_nxt[i*WIDTH +: WIDTH] = clr ? '0 :
                                load[i] ? (lv > MAXV ? MAXV : lv) :
                                !en_eff[i] ? qi :
                                up[i] ? (qi == MAXV ? '0 : qi + WIDTH'(1)) :
                                        (qi == '0 ? MAXV : qi - WIDTH'(1));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= '0;
      tc <= '0;
    end else begin
      q  <= q_nxt;
      tc <= wrap;
    end
  end
endmodule

// File: tb/tb_counter_multi.sv
// tb_counter_multi: randomized and directed stimulus with a scoreboard against a modulo-arithmetic model.
module tb_counter_multi;
  localparam int W = 4;
  localparam int C = 2;
  localparam int M = 9;
  logic           clk = 1'b0;
  logic           rst_n, clr;
  logic [C-1:0]   en, up, load, tc;
  logic [C*W-1:0] load_val, q;
  logic [C*W+C-1:0] sb[$];
  logic [C*W+C-1:0] mon_e;
  int checks = 0;
  int errors = 0;
  int mq[C];
  bit mtc[C];

  counter_multi #(.WIDTH(W), .CHANNELS(C), .MAX_VAL(M)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up),
    .load(load), .load_val(load_val), .q(q), .tc(tc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if ({tc, q} !== mon_e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got q=%h tc=%b, expected q=%h tc=%b",
                 $time, q, tc, mon_e[C*W-1:0], mon_e[C*W+C-1:C*W]);
      end
    end
  end

  task automatic step(input bit c, input bit [C-1:0] e, input bit [C-1:0] u,
                      input bit [C-1:0] l, input bit [C*W-1:0] v);
    bit carry, cnt, wrapped;
    int lvi;
    logic [C*W+C-1:0] exp_v;
    clr = c; en = e; up = u; load = l; load_val = v;
    carry = 1'b1;
    for (int i = 0; i < C; i++) begin
      lvi = int'(v[i*W +: W]);
      cnt = e[i];
`ifdef COUNTER_MULTI_CASCADE_EN
      if (i > 0) cnt = e[i] && carry;
`endif
      wrapped = 1'b0;
      if (c) mq[i] = 0;
      else if (l[i]) mq[i] = (lvi > M) ? M : lvi;
      else if (cnt) begin
        if (u[i]) begin
          wrapped = (mq[i] == M);
          mq[i] = (mq[i] + 1) % (M + 1);
        end else begin
          wrapped = (mq[i] == 0);
          mq[i] = (mq[i] + M) % (M + 1);
        end
      end
      mtc[i] = wrapped;
      carry = wrapped;
    end
    for (int i = 0; i < C; i++) begin
      exp_v[i*W +: W] = W'(mq[i]);
      exp_v[C*W + i]  = mtc[i];
    end
    sb.push_back(exp_v);
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (q !== '0 || tc !== '0) begin
      errors++;
      $display("FAIL %s: got q=%h tc=%b, expected q=0 tc=0", name, q, tc);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; en = '0; up = '0; load = '0; load_val = '0;
    for (int i = 0; i < C; i++) begin mq[i] = 0; mtc[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #2;
    check_reset("reset_state");
    rst_n = 1'b1;
    repeat (20) step(0, 2'b01, 2'b01, 2'b00, 8'h00);
    step(0, 2'b00, 2'b00, 2'b10, 8'h20);
    repeat (3) step(0, 2'b10, 2'b00, 2'b00, 8'h00);
    step(0, 2'b10, 2'b10, 2'b00, 8'h00);
    step(0, 2'b00, 2'b00, 2'b11, 8'hFF);
    step(0, 2'b00, 2'b00, 2'b01, 8'h0F);
    step(0, 2'b00, 2'b00, 2'b01, 8'h03);
    step(0, 2'b01, 2'b01, 2'b01, 8'h05);
    step(1, 2'b11, 2'b11, 2'b11, 8'h55);
    repeat (5) step(0, 2'b10, 2'b11, 2'b00, 8'h00);
    step(1, 2'b00, 2'b00, 2'b00, 8'h00);
    repeat (100) step(0, 2'b11, 2'b11, 2'b00, 8'h00);
    repeat (12) step(0, 2'b11, 2'b00, 2'b00, 8'h00);
    step(0, 2'b00, 2'b00, 2'b01, 8'h07);
    rst_n = 1'b0;
    #1;
    check_reset("async_reset_midcount");
    for (int i = 0; i < C; i++) begin mq[i] = 0; mtc[i] = 1'b0; end
    @(posedge clk);
    #2;
    check_reset("reset_held");
    rst_n = 1'b1;
    repeat (3) step(0, 2'b01, 2'b01, 2'b00, 8'h00);
    repeat (400)
      step($urandom_range(0, 19) == 0, 2'($urandom), 2'($urandom),
           ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, 8'($urandom));
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
